// File: rtl/fpu_issue_arbiter.sv
// Arbitrates NUM_REQ issue requesters onto one FPU port, renames transaction IDs to internal tags
// and routes tagged results back. Define FPU_ARB_RR_EN for round-robin; default is fixed priority.
module fpu_issue_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int TRANS_ID_W = 3,
    parameter int PAYLOAD_W  = 256,
    parameter int FLEN       = 64,
    parameter int NUM_TAGS   = 4,
    localparam int TAG_W     = $clog2(NUM_TAGS),
    localparam int OWN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][TRANS_ID_W-1:0]   req_trans_id_i,
    input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0]    req_payload_i,
    output logic                                 fpu_valid_o,
    input  logic                                 fpu_ready_i,
    output logic [PAYLOAD_W-1:0]                 fpu_payload_o,
    output logic [TAG_W-1:0]                     fpu_tag_o,
    input  logic                                 fpu_res_valid_i,
    input  logic [TAG_W-1:0]                     fpu_res_tag_i,
    input  logic [FLEN-1:0]                      fpu_result_i,
    input  logic                                 fpu_exc_i,
    output logic [NUM_REQ-1:0]                   resp_valid_o,
    output logic [TRANS_ID_W-1:0]                resp_trans_id_o,
    output logic [FLEN-1:0]                      resp_result_o,
    output logic                                 resp_exc_o,
    output logic                                 busy_o
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [OWN_W-1:0]      grant_q, grant_d;
    logic [NUM_TAGS-1:0]   used_q, used_d;
    logic [OWN_W-1:0]      owner_q [NUM_TAGS];
    logic [TRANS_ID_W-1:0] tid_q   [NUM_TAGS];

    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [TRANS_ID_W-1:0] resp_tid_q;
    logic [FLEN-1:0]       resp_result_q;
    logic                  resp_exc_q;
    logic                  busy_q;

    logic [TAG_W-1:0]      free_tag;
    logic                  tag_avail;
    logic [OWN_W-1:0]      winner;
    logic                  any_valid;
    logic [OWN_W-1:0]      sel;
    logic                  sel_valid;
    logic                  issue_valid;
    logic                  handshake;
    logic                  res_hit;

`ifdef FPU_ARB_RR_EN
    logic [OWN_W-1:0]      rr_ptr_q, rr_ptr_d;
`endif

    // Availability looks only at registered state, so a tag freed this cycle is not reused until next.
    always_comb begin
        free_tag  = '0;
        tag_avail = |(~used_q);
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!used_q[i]) free_tag = TAG_W'(i);
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FPU_ARB_RR_EN
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`else
            idx = i;
`endif
            if (!any_valid && req_valid_i[idx]) begin
                any_valid = 1'b1;
                winner    = OWN_W'(idx);
            end
        end
    end

    assign sel         = (state_q == ST_HOLD) ? grant_q : winner;
    assign sel_valid   = (state_q == ST_HOLD) ? req_valid_i[grant_q] : any_valid;
    // Reset and flush both block any handshake on the issue side.
    assign issue_valid = !rst_i && !flush_i && sel_valid && tag_avail;
    assign handshake   = issue_valid && fpu_ready_i;
    assign res_hit     = fpu_res_valid_i && used_q[fpu_res_tag_i] && !flush_i;

    always_comb begin
        req_ready_o      = '0;
        req_ready_o[sel] = handshake;
    end

    assign fpu_valid_o   = issue_valid;
    assign fpu_payload_o = issue_valid ? req_payload_i[sel] : '0;
    assign fpu_tag_o     = issue_valid ? free_tag : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (flush_i) begin
            state_d = ST_ARB;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (issue_valid && !fpu_ready_i) begin
                        state_d = ST_HOLD;
                        grant_d = winner;
                    end
                end
                ST_HOLD: begin
                    if (handshake || !req_valid_i[grant_q]) state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    always_comb begin
        used_d = used_q;
        if (handshake) used_d[free_tag] = 1'b1;
        if (res_hit)   used_d[fpu_res_tag_i] = 1'b0;
        if (flush_i)   used_d = '0;
    end

    always_comb begin
        resp_valid_d = '0;
        if (res_hit) resp_valid_d[owner_q[fpu_res_tag_i]] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_ARB;
            grant_q       <= '0;
            used_q        <= '0;
            busy_q        <= 1'b0;
            resp_valid_q  <= '0;
            resp_tid_q    <= '0;
            resp_result_q <= '0;
            resp_exc_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            used_q       <= used_d;
            busy_q       <= |used_d;
            resp_valid_q <= resp_valid_d;
            if (res_hit) begin
                resp_tid_q    <= tid_q[fpu_res_tag_i];
                resp_result_q <= fpu_result_i;
                resp_exc_q    <= fpu_exc_i;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                owner_q[gi] <= '0;
                tid_q[gi]   <= '0;
            end else if (handshake && free_tag == TAG_W'(gi)) begin
                owner_q[gi] <= sel;
                tid_q[gi]   <= req_trans_id_i[sel];
            end
        end
    end

`ifdef FPU_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) rr_ptr_d = (int'(sel) + 1 >= NUM_REQ) ? '0 : sel + OWN_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign resp_valid_o    = resp_valid_q;
    assign resp_trans_id_o = resp_tid_q;
    assign resp_result_o   = resp_result_q;
    assign resp_exc_o      = resp_exc_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter: issue-side checks inline, responses through a scoreboard queue.
module tb_fpu_issue_arbiter;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][2:0]       req_tid;
    logic [1:0][255:0]     req_payload;
    logic                  fpu_valid;
    logic                  fpu_ready;
    logic [255:0]          fpu_payload;
    logic [1:0]            fpu_tag;
    logic                  res_valid;
    logic [1:0]            res_tag;
    logic [63:0]           res_data;
    logic                  res_exc;
    logic [1:0]            resp_valid;
    logic [2:0]            resp_tid;
    logic [63:0]           resp_result;
    logic                  resp_exc;
    logic                  busy;

    typedef struct {
        logic [1:0]  onehot;
        logic [2:0]  id;
        logic [63:0] res;
        logic        exc;
    } exp_t;

    exp_t        sb[$];
    int          exp_owner [4];
    logic [2:0]  exp_tid   [4];
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    fpu_issue_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_trans_id_i  (req_tid),
        .req_payload_i   (req_payload),
        .fpu_valid_o     (fpu_valid),
        .fpu_ready_i     (fpu_ready),
        .fpu_payload_o   (fpu_payload),
        .fpu_tag_o       (fpu_tag),
        .fpu_res_valid_i (res_valid),
        .fpu_res_tag_i   (res_tag),
        .fpu_result_i    (res_data),
        .fpu_exc_i       (res_exc),
        .resp_valid_o    (resp_valid),
        .resp_trans_id_o (resp_tid),
        .resp_result_o   (resp_result),
        .resp_exc_o      (resp_exc),
        .busy_o          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic v, input logic [1:0] rdy, input logic [1:0] t);
        chk({tag, "_valid"}, 256'(fpu_valid), 256'(v));
        chk({tag, "_ready"}, 256'(req_ready), 256'(rdy));
        if (v) chk({tag, "_tag"}, 256'(fpu_tag), 256'(t));
    endtask

    task automatic send_result(input logic [1:0] t, input logic [63:0] d, input logic e);
        exp_t x;
        res_valid = 1'b1;
        res_tag   = t;
        res_data  = d;
        res_exc   = e;
        x.onehot  = 2'(1 << exp_owner[t]);
        x.id      = exp_tid[t];
        x.res     = d;
        x.exc     = e;
        sb.push_back(x);
    endtask

    task automatic chk_resp(input string tag);
        exp_t x;
        vectors++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed resp_valid %b expected a queued response", tag, resp_valid);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({tag, "_rv"},  256'(resp_valid),  256'(x.onehot));
            chk({tag, "_id"},  256'(resp_tid),    256'(x.id));
            chk({tag, "_res"}, 256'(resp_result), 256'(x.res));
            chk({tag, "_exc"}, 256'(resp_exc),    256'(x.exc));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] g;
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_tid = '0; req_payload = '0;
        fpu_ready = 1'b0; res_valid = 1'b0; res_tag = '0; res_data = '0; res_exc = 1'b0;
        for (int t = 0; t < 4; t++) begin exp_owner[t] = 0; exp_tid[t] = '0; end
        tick();
        #1;
        chk("rst_valid", 256'(fpu_valid), 256'd0);
        chk("rst_ready", 256'(req_ready), 256'd0);
        chk("rst_busy",  256'(busy), 256'd0);
        chk("rst_resp",  256'(resp_valid), 256'd0);
        req_valid = 2'b01; req_payload[0] = {8{32'hC0DE_0001}}; fpu_ready = 1'b1;
        #1;
        chk("rst_gate_valid",   256'(fpu_valid), 256'd0);
        chk("rst_gate_payload", fpu_payload, 256'd0);
        tick();
        rst = 1'b0;

        // Single transaction round trip
        req_tid[0] = 3'd5;
        #1;
        chk_issue("t1", 1'b1, 2'b01, 2'd0);
        chk("t1_payload", fpu_payload, {8{32'hC0DE_0001}});
        exp_owner[0] = 0; exp_tid[0] = 3'd5;
        tick();
        req_valid = '0;
        send_result(2'd0, 64'h3FF0_0000_0000_0000, 1'b0);
        #1;
        chk("t1_busy", 256'(busy), 256'd1);
        tick();
        res_valid = 1'b0;
        #1;
        chk_resp("t1_resp");
        chk("t1_busy_after", 256'(busy), 256'd0);
        tick();
        chk("t1_resp_one_cycle", 256'(resp_valid), 256'd0);

        // Both requesters valid: fill all four tags
        do_reset();
        req_valid = 2'b11; fpu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_tid[0] = 3'(k + 1);
            req_tid[1] = 3'(k + 4);
            req_payload[0] = {8{32'hAA00_0000 + 32'(k)}};
            req_payload[1] = {8{32'hBB00_0000 + 32'(k)}};
`ifdef FPU_ARB_RR_EN
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            g = 2'b01;
`endif
            #1;
            chk_issue($sformatf("fill%0d", k), 1'b1, g, 2'(k));
            chk($sformatf("fill%0d_payload", k), fpu_payload, g[0] ? req_payload[0] : req_payload[1]);
            exp_owner[k] = g[0] ? 0 : 1;
            exp_tid[k]   = g[0] ? req_tid[0] : req_tid[1];
            tick();
        end
        #1;
        chk_issue("full", 1'b0, 2'b00, 2'd0);
        req_valid = '0;
        tick();

        // Out-of-order returns; freed tag is reusable only from the following cycle
        send_result(2'd2, 64'h4000_0000_0000_0002, 1'b1);
        req_valid = 2'b01; req_tid[0] = 3'd6; req_payload[0] = {8{32'h1234_5678}};
        #1;
        chk_issue("free_same_cycle", 1'b0, 2'b00, 2'd0);
        tick();
        send_result(2'd0, 64'h4000_0000_0000_0000, 1'b0);
        #1;
        chk_resp("ooo_tag2");
        chk_issue("realloc2", 1'b1, 2'b01, 2'd2);
        exp_owner[2] = 0; exp_tid[2] = 3'd6;
        tick();
        res_valid = 1'b0; req_tid[0] = 3'd7;
        #1;
        chk_resp("ooo_tag0");
        chk_issue("realloc0", 1'b1, 2'b01, 2'd0);
        exp_owner[0] = 0; exp_tid[0] = 3'd7;
        tick();
        req_valid = '0;
        send_result(2'd3, 64'h4000_0000_0000_0003, 1'b0);
        tick();

        // Flush with three outstanding and a simultaneous tag-1 result
        res_valid = 1'b1; res_tag = 2'd1; res_data = 64'hDEAD; res_exc = 1'b0;
        flush = 1'b1; req_valid = 2'b01;
        #1;
        chk_resp("tag3");
        chk_issue("flush_issue", 1'b0, 2'b00, 2'd0);
        tick();
        flush = 1'b0; res_valid = 1'b0; req_valid = '0;
        #1;
        chk("flush_resp", 256'(resp_valid), 256'd0);
        chk("flush_busy", 256'(busy), 256'd0);
        res_valid = 1'b1; res_tag = 2'd1;
        tick();
        res_valid = 1'b0;
        #1;
        chk("stale_drop", 256'(resp_valid), 256'd0);

        // HOLD: requester 1 locked while the FPU stalls
        req_valid = 2'b10; req_tid[1] = 3'd3; fpu_ready = 1'b0;
        req_payload[1] = {8{32'h5A5A_0001}}; req_payload[0] = {8{32'h0F0F_0000}};
        #1;
        chk_issue("hold0", 1'b1, 2'b00, 2'd0);
        tick();
        req_valid = 2'b11;
        for (int k = 1; k < 3; k++) begin
            #1;
            chk_issue($sformatf("hold%0d", k), 1'b1, 2'b00, 2'd0);
            chk($sformatf("hold%0d_payload", k), fpu_payload, {8{32'h5A5A_0001}});
            tick();
        end
        fpu_ready = 1'b1;
        #1;
        chk_issue("hold_release", 1'b1, 2'b10, 2'd0);
        exp_owner[0] = 1; exp_tid[0] = 3'd3;
        tick();
        req_valid = '0; fpu_ready = 1'b0;
        send_result(2'd0, 64'h3FF8_0000_0000_0000, 1'b0);
        tick();
        res_valid = 1'b0;
        #1;
        chk_resp("hold_resp");

        // Asynchronous reset in the middle of a HOLD
        req_valid = 2'b01; req_tid[0] = 3'd2; fpu_ready = 1'b1;
        #1;
        chk_issue("pre_hold", 1'b1, 2'b01, 2'd0);
        tick();
        req_valid = 2'b10; fpu_ready = 1'b0;
        #1;
        chk_issue("enter_hold", 1'b1, 2'b00, 2'd1);
        tick();
        req_valid = 2'b11;
        #1;
        chk("hold_busy", 256'(busy), 256'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",   256'(fpu_valid), 256'd0);
        chk("arst_ready",   256'(req_ready), 256'd0);
        chk("arst_payload", fpu_payload, 256'd0);
        chk("arst_busy",    256'(busy), 256'd0);
        tick();
        rst = 1'b0; fpu_ready = 1'b1;
        #1;
        chk_issue("post_reset", 1'b1, 2'b01, 2'd0);
        tick();
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
